bram_axi_lite_master: RTL

- Converts a BRAM-style requester port (en/we/addr/wrdata) into AXI-lite master transactions, the inverse of the AXI-to-BRAM controller path.
- Lets BRAM-port logic (table walkers, DMA descriptor fetchers, legacy cores) reach AXI-lite slaves through the interconnect.
- AXI latency is variable, so the port adds a ready/stall signal and a read-valid strobe.
- Exactly one transaction is outstanding at a time.

---
 rtl/bram_axi_lite_master.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bram_axi_lite_master.sv
// BRAM-style requester port to AXI-lite master bridge.
// One transaction outstanding; completion reported by rdvalid/wrdone pulses.
module bram_axi_lite_master #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int BRAM_ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       req_en,
    input  logic [DATA_WIDTH/8-1:0]    req_we,
    input  logic [BRAM_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wrdata,
    output logic                       req_ready,
    output logic [DATA_WIDTH-1:0]      req_rddata,
    output logic                       req_rdvalid,
    output logic                       req_wrdone,
    output logic                       req_err,
    output logic [ADDR_WIDTH-1:0]      m_awaddr,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    output logic [DATA_WIDTH-1:0]      m_wdata,
    output logic [DATA_WIDTH/8-1:0]    m_wstrb,
    output logic                       m_wvalid,
    input  logic                       m_wready,
    input  logic [1:0]                 m_bresp,
    input  logic                       m_bvalid,
    output logic                       m_bready,
    output logic [ADDR_WIDTH-1:0]      m_araddr,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    input  logic [DATA_WIDTH-1:0]      m_rdata,
    input  logic [1:0]                 m_rresp,
    input  logic                       m_rvalid,
    output logic                       m_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(STRB_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP
    } state_t;

    state_t state, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] byte_addr;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0] rddata_q;
    logic aw_done, w_done;
    logic rdvalid_q, wrdone_q, err_q;
    logic accept, aw_hs, w_hs, r_hs, b_hs;

    assign byte_addr = ADDR_BASE + (ADDR_WIDTH'(req_addr) << SHIFT);
    assign accept = req_en & (state == IDLE);

    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign r_hs  = m_rready & m_rvalid;
    assign b_hs  = m_bready & m_bvalid;

    assign m_araddr    = addr_q;
    assign m_awaddr    = addr_q;
    assign m_wdata     = wdata_q;
    assign m_wstrb     = wstrb_q;
    assign req_rddata  = rddata_q;
    assign req_rdvalid = rdvalid_q;
    assign req_wrdone  = wrdone_q;
    assign req_err     = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // All channel controls decode from state only, so no req_* to m_* path exists.
    always_comb begin
        state_d   = state;
        req_ready = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_en) begin
                    state_d = (|req_we) ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid) state_d = IDLE;
            end
            WR_ADDR_DATA: begin
                m_awvalid = ~aw_done;
                m_wvalid  = ~w_done;
                if ((aw_done | m_awready) & (w_done | m_wready)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (accept) begin
            addr_q  <= byte_addr;
            wdata_q <= req_wrdata;
            wstrb_q <= req_we;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
        end
    end

    // Read data survives writes and errors; only a completed read replaces it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rddata_q  <= '0;
            rdvalid_q <= 1'b0;
            wrdone_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (r_hs) rddata_q <= m_rdata;
            rdvalid_q <= r_hs;
            wrdone_q  <= b_hs;
            err_q     <= (r_hs & (m_rresp != 2'b00)) |
                         (b_hs & (m_bresp != 2'b00));
        end
    end

endmodule
